// File: rtl/loader_sink.sv
// loader_sink: packs the byte-wide loader stream into 16-bit SDRAM word writes.
// An even byte is parked until its odd partner arrives. An orphaned byte is
// written alone, with only its own byte-lane enable set.
// Optional feature: define LOADER_SINK_CHECKSUM_EN to add ldr_sum, a 16-bit
// running sum of all accepted bytes.
module loader_sink (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ldr_oe,
    input  logic        ldr_wr,
    input  logic [18:0] ldr_adr,
    input  logic [7:0]  ldr_wdat,
    output logic        ldr_ack,
    output logic        mem_req,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdat,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    output logic        busy
`ifdef LOADER_SINK_CHECKSUM_EN
    ,
    output logic [15:0] ldr_sum
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAITLOW,
        ST_WRITE,
        ST_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic        held_q, held_d;
    logic [17:0] hold_addr_q, hold_addr_d;
    logic [7:0]  hold_dat_q, hold_dat_d;
    logic [17:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdat_q, mem_wdat_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic        byte_take;
    logic        word_match;
    logic        do_flush;

    // Qualified byte strobe and pairing test against the parked even byte
    always_comb begin
        byte_take  = ldr_oe && ldr_wr;
        word_match = held_q && (hold_addr_q == ldr_adr[18:1]);
    end

    // State and datapath registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            held_q      <= 1'b0;
            hold_addr_q <= '0;
            hold_dat_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdat_q  <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            hold_addr_q <= hold_addr_d;
            hold_dat_q  <= hold_dat_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdat_q  <= mem_wdat_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Next-state decision and datapath loads
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        hold_addr_d = hold_addr_q;
        hold_dat_d  = hold_dat_q;
        mem_addr_d  = mem_addr_q;
        mem_wdat_d  = mem_wdat_q;
        mem_be_d    = mem_be_q;
        do_flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A parked byte with the window closed can only mean ldr_oe fell
                // after the byte was taken, so this level test replaces an edge detector.
                if (held_q && !ldr_oe) begin
                    do_flush = 1'b1;
                end else if (byte_take) begin
                    if (!ldr_adr[0]) begin
                        if (held_q) begin
                            do_flush = 1'b1;
                        end else begin
                            held_d      = 1'b1;
                            hold_addr_d = ldr_adr[18:1];
                            hold_dat_d  = ldr_wdat;
                            state_d     = ST_ACK;
                        end
                    end else if (word_match) begin
                        mem_addr_d = ldr_adr[18:1];
                        mem_wdat_d = {ldr_wdat, hold_dat_q};
                        mem_be_d   = 2'b11;
                        state_d    = ST_WRITE;
                    end else if (held_q) begin
                        do_flush = 1'b1;
                    end else begin
                        mem_addr_d = ldr_adr[18:1];
                        mem_wdat_d = {ldr_wdat, 8'h00};
                        mem_be_d   = 2'b10;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    held_d  = 1'b0;
                    state_d = ST_ACK;
                end
            end
            ST_FLUSH: begin
                // The byte that forced the flush is still on the bus; IDLE re-evaluates it.
                if (mem_ack) begin
                    held_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_WAITLOW;
            end
            ST_WAITLOW: begin
                if (!ldr_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_flush) begin
            mem_addr_d = hold_addr_q;
            mem_wdat_d = {8'h00, hold_dat_q};
            mem_be_d   = 2'b01;
            state_d    = ST_FLUSH;
        end
    end

`ifdef LOADER_SINK_CHECKSUM_EN
    logic [7:0]  sum_byte_q, sum_byte_d;
    logic [15:0] ldr_sum_q, ldr_sum_d;

    // Capture the byte being accepted and fold it into the sum during the ldr_ack cycle
    always_comb begin
        sum_byte_d = sum_byte_q;
        ldr_sum_d  = ldr_sum_q;
        if ((state_q == ST_IDLE) && ((state_d == ST_ACK) || (state_d == ST_WRITE))) begin
            sum_byte_d = ldr_wdat;
        end
        if (state_q == ST_ACK) begin
            ldr_sum_d = ldr_sum_q + {8'h00, sum_byte_q};
        end
    end

    // Checksum registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_byte_q <= '0;
            ldr_sum_q  <= '0;
        end else begin
            sum_byte_q <= sum_byte_d;
            ldr_sum_q  <= ldr_sum_d;
        end
    end
`endif

    // Outputs decoded from state plus registered write payload
    always_comb begin
        ldr_ack  = (state_q == ST_ACK);
        mem_req  = (state_q == ST_WRITE) || (state_q == ST_FLUSH);
        busy     = (state_q != ST_IDLE) || held_q;
        mem_addr = mem_addr_q;
        mem_wdat = mem_wdat_q;
        mem_be   = mem_be_q;
`ifdef LOADER_SINK_CHECKSUM_EN
        ldr_sum  = ldr_sum_q;
`endif
    end

endmodule

// File: doc/loader_sink.md
LOADER_SINK -- requirements
Module: loader_sink

Interface
REQ-001 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port ldr_oe  in  1  load window active (download in progress, not done).
REQ-004 SHALL have port ldr_wr  in  1  byte-valid level, held by initiator until ldr_ack seen.
REQ-005 SHALL have port ldr_adr  in  19  byte address.
REQ-006 SHALL have port ldr_wdat  in  8  byte data.
REQ-007 SHALL have port ldr_ack  out  1  one-cycle acknowledge pulse per accepted byte.
REQ-008 SHALL have port mem_req  out  1  write request to SDRAM arbiter, level until mem_ack.
REQ-009 SHALL have port mem_addr  out  18  word address (ldr_adr[18:1]).
REQ-010 SHALL have port mem_wdat  out  16  word data, even byte in [7:0], odd byte in [15:8].
REQ-011 SHALL have port mem_be  out  2  byte enables, bit0 = low byte.
REQ-012 SHALL have port mem_ack  in  1  one-cycle completion pulse from arbiter.
REQ-013 SHALL have port busy  out  1  high when in any state other than IDLE or when an even byte is held.

Function
REQ-014 SHALL implement states IDLE, ACK, WAITLOW, WRITE, FLUSH.
REQ-015 IDLE, ldr_oe=1, ldr_wr=1, ldr_adr[0]=0, no held byte: latch byte and word address, set held flag, go ACK.
REQ-016 IDLE, ldr_wr=1, ldr_adr[0]=1, held byte with matching word address: drive mem_req with be=11, go WRITE.
REQ-017 IDLE, ldr_wr=1, odd byte with no held byte: write be=10, go WRITE.
REQ-018 IDLE, ldr_wr=1, held byte whose word address differs from ldr_adr[18:1], or a second even byte: go FLUSH first (be=01 write of held byte, byte not yet accepted), then re-evaluate from IDLE.
REQ-019 WRITE: hold mem_req/addr/wdat/be stable until mem_ack; on mem_ack clear held flag, deassert mem_req next cycle, go ACK.
REQ-020 ACK: ldr_ack=1 for exactly one cycle, go WAITLOW.
REQ-021 WAITLOW: stay until ldr_wr=0, then IDLE; a held ldr_wr SHALL never be accepted twice.
REQ-022 Latency: even byte ldr_wr to ldr_ack = 2 cycles; odd byte = mem_ack cycle + 2.
REQ-023 Falling edge of ldr_oe with a held byte: FLUSH with be=01, no ldr_ack generated; without held byte: no action.
REQ-024 ldr_wr while ldr_oe=0: ignored, no ack.
REQ-025 mem_ack outside WRITE/FLUSH: ignored.
REQ-026 Address wrap: 0x7FFFF odd byte SHALL write word 0x3FFFF; no carry into other state.

Reset
REQ-027 reset SHALL force IDLE, clear held flag, ldr_ack=0, mem_req=0, mem_addr=0, mem_wdat=0, mem_be=0, busy=0 in the next cycle.
REQ-028 reset mid-WRITE SHALL drop mem_req immediately; the pending byte is lost and not acknowledged.

Configuration
REQ-029 With LOADER_SINK_CHECKSUM_EN defined, module SHALL add output ldr_sum (16 bits), reset to 0, adding each accepted byte zero-extended, modulo 2^16, in the ldr_ack cycle.
REQ-030 Without LOADER_SINK_CHECKSUM_EN, ldr_sum port and adder SHALL not exist; all other behaviour identical.

Verification
REQ-031 Bytes 0x12@0x00000 then 0x34@0x00001, mem_ack 3 cycles after req -> one write addr=0, wdat=0x3412, be=11; two ldr_ack pulses.
REQ-032 Byte 0xAA@0x00010 then ldr_oe falls -> flush write addr=0x00008, wdat[7:0]=0xAA, be=01; exactly one ldr_ack.
REQ-033 Even 0x55@0x00020 then odd 0x66@0x00031 -> write addr=0x10 be=01, then addr=0x18 wdat[15:8]=0x66 be=10.
REQ-034 ldr_wr held high 10 cycles after ldr_ack -> no second ack, no extra mem_req.
REQ-035 reset asserted while mem_req=1 -> next cycle mem_req=0, busy=0, state IDLE.
REQ-036 With LOADER_SINK_CHECKSUM_EN: bytes 0xFF,0xFF,0x02 -> ldr_sum=0x0200.
